// File: rtl/shared_reg_if.sv
// Request/grant bus between N_REQ producers and the shared write register.
// Producers drive req/data; the arbiter returns grant and register state.
interface shared_reg_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [IDX_W-1:0]       owner;
    logic                   busy;

    modport master (
        output req, data,
        input  gnt, q, q_valid, owner, busy
    );

    modport slave (
        input  req, data,
        output gnt, q, q_valid, owner, busy
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one register among N_REQ requesters,
// with a fixed dead time after every accepted write.
module shared_reg_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input logic        clk,
    input logic        rst,
    shared_reg_if.slave bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] ptr_nxt;
    logic [7:0]       cnt;
    logic             hit;
    int               idx;

    // Search starts at ptr and wraps, so the last winner ends up lowest.
    always_comb begin
        win  = '0;
        cand = '0;
        hit  = 1'b0;
        idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDX_W'(idx);
            if (!hit && bus.req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    assign ptr_nxt = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;

    assign bus.gnt = (rst && state == IDLE && hit)
                   ? ({{(N_REQ-1){1'b0}}, 1'b1} << win)
                   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
            bus.owner   <= '0;
            bus.busy    <= 1'b0;
        end else begin
            bus.q_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        bus.q       <= bus.data[win*WIDTH +: WIDTH];
                        bus.owner   <= win;
                        bus.q_valid <= 1'b1;
                        ptr         <= ptr_nxt;
                        if (HOLD_CYCLES > 0) begin
                            state    <= HOLD;
                            cnt      <= 8'(HOLD_CYCLES);
                            bus.busy <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == 8'd1) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench: one arbiter with a 2-cycle dead time, one with none.
// Inputs change on negedge; outputs are sampled 1ns after negedge.
module tb_shared_reg_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    shared_reg_if #(.N_REQ(4), .WIDTH(8)) b2 ();
    shared_reg_if #(.N_REQ(4), .WIDTH(8)) b0 ();

    shared_reg_arbiter #(
        .N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)
    ) u_h2 (
        .clk(clk),
        .rst(rst),
        .bus(b2.slave)
    );

    shared_reg_arbiter #(
        .N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)
    ) u_h0 (
        .clk(clk),
        .rst(rst),
        .bus(b0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!done && !b2.busy) done = 1'b1;
            if (!done) begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [3:0] e;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        b2.req  = '0;
        b2.data = '0;
        b0.req  = '0;
        b0.data = '0;

        // Reset with all requests pending
        #2;
        rst    = 1'b0;
        b2.req = 4'b1111;
        b0.req = 4'b1111;
        @(negedge clk);
        #1;
        check("rst_gnt", b2.gnt, 4'b0000);
        check("rst_gnt_h0", b0.gnt, 4'b0000);
        check("rst_q", b2.q, 8'h00);
        check("rst_qv", b2.q_valid, 1'b0);
        check("rst_owner", b2.owner, 2'd0);
        check("rst_busy", b2.busy, 1'b0);
        rst             = 1'b1;
        b0.req          = '0;
        b2.data[7:0]    = 8'h11;
        #1;
        check("first_gnt", b2.gnt, 4'b0001);
        step();
        check("first_q", b2.q, 8'h11);
        check("first_qv", b2.q_valid, 1'b1);
        check("first_busy", b2.busy, 1'b1);
        b2.req = '0;
        wait_idle();

        // Single write to requester 2
        b2.req          = 4'b0100;
        b2.data[23:16]  = 8'hA5;
        #1;
        check("sw_gnt", b2.gnt, 4'b0100);
        step();
        check("sw_q", b2.q, 8'hA5);
        check("sw_owner", b2.owner, 2'd2);
        check("sw_qv", b2.q_valid, 1'b1);
        check("sw_busy1", b2.busy, 1'b1);
        check("sw_gnt_hold", b2.gnt, 4'b0000);
        b2.req = '0;
        @(negedge clk);
        #1;
        check("sw_busy2", b2.busy, 1'b1);
        check("sw_qv_drop", b2.q_valid, 1'b0);
        @(negedge clk);
        #1;
        check("sw_idle", b2.busy, 1'b0);

        // Wrap from ptr=3 to 0, skipping idle requester 3
        b2.req         = 4'b0011;
        b2.data[7:0]   = 8'h5A;
        b2.data[15:8]  = 8'h6B;
        #1;
        check("wrap_gnt0", b2.gnt, 4'b0001);
        step();
        check("wrap_q0", b2.q, 8'h5A);
        check("wrap_own0", b2.owner, 2'd0);
        b2.req = 4'b0010;
        wait_idle();
        check("wrap_gnt1", b2.gnt, 4'b0010);
        step();
        check("wrap_q1", b2.q, 8'h6B);
        check("wrap_own1", b2.owner, 2'd1);
        b2.req = '0;
        wait_idle();

        // Single persistent requester blocked by dead time
        b2.req       = 4'b0001;
        b2.data[7:0] = 8'h77;
        #1;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("hb_gnt%0d", c), b2.gnt,
                  (c % 3 == 0) ? 4'b0001 : 4'b0000);
            check($sformatf("hb_qv%0d", c), b2.q_valid,
                  (c % 3 == 1) ? 1'b1 : 1'b0);
            step();
        end
        b2.req = '0;
        wait_idle();

        // Reset in the middle of the dead time
        b2.req          = 4'b1000;
        b2.data[31:24]  = 8'h3C;
        #1;
        check("mh_gnt", b2.gnt, 4'b1000);
        step();
        check("mh_q", b2.q, 8'h3C);
        check("mh_busy", b2.busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mh_rst_q", b2.q, 8'h00);
        check("mh_rst_busy", b2.busy, 1'b0);
        check("mh_rst_owner", b2.owner, 2'd0);
        check("mh_rst_gnt", b2.gnt, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mh_rel_gnt", b2.gnt, 4'b1000);
        step();
        check("mh_rel_q", b2.q, 8'h3C);
        check("mh_rel_owner", b2.owner, 2'd3);
        b2.req = '0;

        // Back-to-back round robin with no dead time
        b0.data = {8'h13, 8'h12, 8'h11, 8'h10};
        b0.req  = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            check($sformatf("rr_gnt%0d", k), b0.gnt, e);
            step();
            check($sformatf("rr_q%0d", k), b0.q, 8'h10 + k % 4);
            check($sformatf("rr_own%0d", k), b0.owner, k % 4);
            check($sformatf("rr_qv%0d", k), b0.q_valid, 1'b1);
            check($sformatf("rr_busy%0d", k), b0.busy, 1'b0);
        end
        b0.req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
